// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - parametrised VGA scan generator with fetch-latency compensation
// Optional colour-bar test pattern: define VGA_TESTPAT_EN to add the tp_sel input.
module vga_scan_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter int COLOR_W   = 1,
  parameter int FETCH_LAT = 2,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
`ifdef VGA_TESTPAT_EN
  input  logic                   tp_sel,
`endif
  input  logic [3*COLOR_W-1:0]   pix_rgb,
  output logic [HW-1:0]          hcnt,
  output logic [VW-1:0]          vcnt,
  output logic                   pix_tick,
  output logic                   pix_req,
  output logic                   frame_start,
  output logic [7:0]             frame_cnt,
  output logic                   vga_HS,
  output logic                   vga_VS,
  output logic [COLOR_W-1:0]     vga_R,
  output logic [COLOR_W-1:0]     vga_G,
  output logic [COLOR_W-1:0]     vga_B
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

`ifdef VGA_TESTPAT_EN
  localparam logic [HW-1:0] H_BAR    = HW'(H_ACTIVE / 8);
  typedef struct packed {logic act; logic hs; logic vs; logic [2:0] bar;} flags_t;
`else
  typedef struct packed {logic act; logic hs; logic vs;} flags_t;
`endif

  logic [DW-1:0]        div_cnt;
  logic [HW-1:0]        h_nxt;
  logic [VW-1:0]        v_nxt;
  logic                 wrap;
  flags_t               flags_cur;
  flags_t               flags_out;
  logic [3*COLOR_W-1:0] src_rgb;
  logic [3*COLOR_W-1:0] rgb_q;

  always_comb begin
    h_nxt = hcnt;
    v_nxt = vcnt;
    wrap  = 1'b0;
    if (pix_tick) begin
      if (hcnt == H_LAST) begin
        h_nxt = '0;
        if (vcnt == V_LAST) begin
          v_nxt = '0;
          wrap  = 1'b1;
        end else begin
          v_nxt = vcnt + VW'(1);
        end
      end else begin
        h_nxt = hcnt + HW'(1);
      end
    end
  end

  always_comb begin
    flags_cur     = '0;
    flags_cur.act = (hcnt < H_ACT) && (vcnt < V_ACT);
    flags_cur.hs  = (hcnt >= HS_BEG) && (hcnt <= HS_END);
    flags_cur.vs  = (vcnt >= VS_BEG) && (vcnt <= VS_END);
`ifdef VGA_TESTPAT_EN
    flags_cur.bar = 3'(hcnt / H_BAR);
`endif
  end

  // Flags trail the counters by FETCH_LAT ticks so they meet the matching pix_rgb.
  generate
    if (FETCH_LAT == 0) begin : g_no_dly
      assign flags_out = flags_cur;
    end else begin : g_dly
      flags_t dly [FETCH_LAT];
      always_ff @(posedge clk) begin
        if (rst || !enable) begin
          for (int i = 0; i < FETCH_LAT; i++) dly[i] <= '0;
        end else if (pix_tick) begin
          dly[0] <= flags_cur;
          for (int i = 1; i < FETCH_LAT; i++) dly[i] <= dly[i-1];
        end
      end
      assign flags_out = dly[FETCH_LAT-1];
    end
  endgenerate

`ifdef VGA_TESTPAT_EN
  assign src_rgb = tp_sel ? {{COLOR_W{flags_out.bar[2]}}, {COLOR_W{flags_out.bar[1]}},
                             {COLOR_W{flags_out.bar[0]}}} : pix_rgb;
`else
  assign src_rgb = pix_rgb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt     <= '0;
      pix_tick    <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      vga_HS      <= ~HS_POL;
      vga_VS      <= ~VS_POL;
      rgb_q       <= '0;
    end else if (!enable) begin
      div_cnt     <= '0;
      pix_tick    <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
      vga_HS      <= ~HS_POL;
      vga_VS      <= ~VS_POL;
      rgb_q       <= '0;
    end else begin
      pix_tick    <= (div_cnt == DIV_LAST);
      div_cnt     <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      hcnt        <= h_nxt;
      vcnt        <= v_nxt;
      pix_req     <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      frame_start <= wrap;
      if (wrap) frame_cnt <= frame_cnt + 8'd1;
      if (pix_tick) begin
        vga_HS <= flags_out.hs ? HS_POL : ~HS_POL;
        vga_VS <= flags_out.vs ? VS_POL : ~VS_POL;
        rgb_q  <= (flags_out.act && !clear) ? src_rgb : '0;
      end
    end
  end

  assign vga_R = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign vga_G = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign vga_B = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen (small timing, CLK_DIV=2, FETCH_LAT=2)
module tb_vga_scan_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int D  = 2;
  localparam int FL = 2;
  localparam int CW = 4;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b1;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
`ifdef VGA_TESTPAT_EN
  localparam bit TP_BUILD = 1'b1;
`else
  localparam bit TP_BUILD = 1'b0;
`endif

  typedef struct {
    logic          tick;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          req;
    logic          fs;
    logic [7:0]    fc;
    logic          hs;
    logic          vs;
    logic [3*CW-1:0] rgb;
  } exp_t;

  typedef struct {
    bit rst;
    bit en;
    bit clr;
    bit tp;
    int cycles;
    int exp_fc;
  } phase_t;

  logic clk, rst, enable, clear;
`ifdef VGA_TESTPAT_EN
  logic tp_sel;
`endif
  logic [3*CW-1:0] pix_rgb;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic pix_tick, pix_req, frame_start, vga_HS, vga_VS;
  logic [7:0] frame_cnt;
  logic [CW-1:0] vga_R, vga_G, vga_B;

  vga_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .CLK_DIV(D), .COLOR_W(CW), .FETCH_LAT(FL), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
`ifdef VGA_TESTPAT_EN
    .tp_sel(tp_sel),
`endif
    .pix_rgb(pix_rgb), .hcnt(hcnt), .vcnt(vcnt), .pix_tick(pix_tick),
    .pix_req(pix_req), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  int mk = 0;
  int base = 0;
  bit cap_clear = 1'b0;
  bit cap_tp = 1'b0;
  logic [3*CW-1:0] src_sr [FL];
  logic [3*CW-1:0] prev_f;
  bit prev_tick = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3*CW-1:0] src_f(input int h, input int v);
    return 12'(h * 37 + v * 101 + 5);
  endfunction

  function automatic logic [3*CW-1:0] bar_rgb(input int h);
    logic [2:0] b;
    b = 3'(h / (HA / 8));
    return {{CW{b[2]}}, {CW{b[1]}}, {CW{b[0]}}};
  endfunction

  function automatic int tcount(input int k);
    return (k >= 1) ? (k - 1) / D : 0;
  endfunction

  // Closed-form expectation: k enabled edges since the last reset/disable.
  function automatic exp_t model(input int k, input int b, input bit cc, input bit ct);
    exp_t e;
    int t, q, hq, vq;
    t     = tcount(k);
    e.tick = (k >= 1) && (k % D == 0);
    e.h   = HW'(t % HT);
    e.v   = VW'((t / HT) % VT);
    e.req = (k >= 1) && (t % HT < HA) && ((t / HT) % VT < VA);
    e.fs  = (k >= 2) && ((k - 1) % D == 0) && (t % FT == 0);
    e.fc  = 8'(b + t / FT);
    e.hs  = !HS_POL;
    e.vs  = !VS_POL;
    e.rgb = '0;
    q = t - 1 - FL;
    if (q >= 0) begin
      hq = q % HT;
      vq = (q / HT) % VT;
      if (hq >= HA + HF && hq < HA + HF + HSW) e.hs = HS_POL;
      if (vq >= VA + VF && vq < VA + VF + VSW) e.vs = VS_POL;
      if (hq < HA && vq < VA && !cc) e.rgb = ct ? bar_rgb(hq) : src_f(hq, vq);
    end
    return e;
  endfunction

  task automatic step(input bit r, input bit e, input bit c, input bit t);
    exp_t x;
    rst = r; enable = e; clear = c;
`ifdef VGA_TESTPAT_EN
    tp_sel = t;
`endif
    if (r) begin
      mk = 0; base = 0;
    end else if (!e) begin
      base = (base + tcount(mk) / FT) % 256;
      mk = 0;
    end else begin
      mk++;
      if (mk >= 2 && (mk - 1) % D == 0) begin
        cap_clear = c;
        cap_tp = TP_BUILD && t;
      end
    end
    sb.push_back(model(mk, base, cap_clear, cap_tp));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk("pix_tick", pix_tick, x.tick);
      chk("hcnt", hcnt, x.h);
      chk("vcnt", vcnt, x.v);
      chk("pix_req", pix_req, x.req);
      chk("frame_start", frame_start, x.fs);
      chk("frame_cnt", frame_cnt, x.fc);
      chk("vga_HS", vga_HS, x.hs);
      chk("vga_VS", vga_VS, x.vs);
      chk("rgb", {vga_R, vga_G, vga_B}, x.rgb);
    end
    // Pixel source: returns data for the fetched position FL ticks later.
    if (prev_tick) begin
      for (int i = FL - 1; i > 0; i--) src_sr[i] = src_sr[i-1];
      src_sr[0] = prev_f;
    end
    prev_tick = pix_tick;
    prev_f = src_f(int'(hcnt), int'(vcnt));
    pix_rgb = src_sr[FL-1];
  endtask

  phase_t phases [8];
  int first_hs, fs_a, fs_b, n;
  bit found;

  initial begin
    rst = 1'b1; enable = 1'b0; clear = 1'b0; pix_rgb = '0; prev_f = '0;
`ifdef VGA_TESTPAT_EN
    tp_sel = 1'b0;
`endif
    for (int i = 0; i < FL; i++) src_sr[i] = '0;

    phases[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3,   0};
    phases[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 402, 2};
    phases[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 28,  2};
    phases[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 200, 3};
    phases[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 10,  3};
    phases[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 100, 3};
    phases[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1,   0};
    phases[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 220, 1};

    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < phases[p].cycles; c++)
        step(phases[p].rst, phases[p].en, phases[p].clr, phases[p].tp);
      chk($sformatf("phase%0d_frame_cnt", p), frame_cnt, 32'(phases[p].exp_fc));
    end

    // Drop enable mid-line at hcnt == 5.
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (hcnt == HW'(5)) found = 1'b1;
    end
    chk("wait_hcnt5", found, 1);
    n = (base + tcount(mk) / FT) % 256;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("drop_hcnt", hcnt, 0);
    chk("drop_vcnt", vcnt, 0);
    chk("drop_hs", vga_HS, !HS_POL);
    chk("drop_vs", vga_VS, !VS_POL);
    chk("drop_rgb", {vga_R, vga_G, vga_B}, 0);
    chk("drop_frame_cnt_held", frame_cnt, 32'(n));
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Re-enable: HS first asserts after 13 ticks of position plus divider start.
    first_hs = -1;
    for (int c = 1; c <= 60; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (first_hs < 0 && vga_HS == HS_POL) first_hs = c;
    end
    chk("reenable_hs_first", 32'(first_hs), 32'((HA + HF + FL + 1) * D + 1));

    // Frame period between consecutive frame_start pulses.
    fs_a = -1; fs_b = -1;
    for (int c = 0; c < 500 && fs_b < 0; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      if (frame_start) begin
        if (fs_a < 0) fs_a = c;
        else fs_b = c;
      end
    end
    chk("frame_period_clks", 32'(fs_b - fs_a), 32'(FT * D));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
